pipe_hazard_ctrl: RTL and testbench

Sequencing controller for the 5-stage pipeline register banks (IF/ID, ID/EX, EX/MEM, MEM/WB). Every cycle it drives a per-bank write enable and a bubble/flush request. It covers load-use hazards, taken branches and data-memory wait states. It keeps its own shadow of the ID/EX destination so that hazard checks use registered state only.

---
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the IF/ID, ID/EX, EX/MEM and MEM/WB banks.
// Define PIPE_HAZARD_STALL_CNT_EN to add the saturating stall_count output.
module pipe_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             flush_ifid,
`ifdef PIPE_HAZARD_STALL_CNT_EN
    output logic             flush_idex,
    output logic [CNT_W-1:0] stall_count
`else
    output logic             flush_idex
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LUS  = 2'd1,
        MEMW = 2'd2
    } state_t;

    localparam logic [REG_W-1:0] ZERO_R = REG_W'(ZERO_REG);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("pipe_hazard_ctrl: CNT_W must be at least 1");
    end

    state_t           state_q, state_d;
    logic             pend_br_q, pend_br_d;
    logic             ex_valid_q, ex_valid_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             ex_load_q, ex_load_d;

    logic             lu;
    logic             en_ifid_c, en_idex_c, en_exmem_c, en_memwb_c;
    logic             flush_ifid_c, flush_idex_c;

    assign lu = ex_valid_q & ex_load_q & (ex_rd_q != ZERO_R) & id_valid &
                ((id_rn_used & (id_rn == ex_rd_q)) | (id_rm_used & (id_rm == ex_rd_q)));

    // LUS shares the RUN rules: its shadow already holds the bubble, so lu is 0.
    always_comb begin
        state_d      = RUN;
        pend_br_d    = pend_br_q;
        en_ifid_c    = 1'b1;
        en_idex_c    = 1'b1;
        en_exmem_c   = 1'b1;
        en_memwb_c   = 1'b1;
        flush_ifid_c = 1'b0;
        flush_idex_c = 1'b0;
        case (state_q)
            MEMW: begin
                if (mem_busy) begin
                    en_ifid_c  = 1'b0;
                    en_idex_c  = 1'b0;
                    en_exmem_c = 1'b0;
                    en_memwb_c = 1'b0;
                    state_d    = MEMW;
                end else if (pend_br_q) begin
                    flush_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                    pend_br_d    = 1'b0;
                end else if (lu) begin
                    en_ifid_c    = 1'b0;
                    flush_idex_c = 1'b1;
                    state_d      = LUS;
                end
            end
            default: begin
                if (mem_busy) begin
                    en_ifid_c  = 1'b0;
                    en_idex_c  = 1'b0;
                    en_exmem_c = 1'b0;
                    en_memwb_c = 1'b0;
                    state_d    = MEMW;
                    if (br_taken) begin
                        pend_br_d = 1'b1;
                    end
                end else if (br_taken) begin
                    flush_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                end else if (lu) begin
                    en_ifid_c    = 1'b0;
                    flush_idex_c = 1'b1;
                    state_d      = LUS;
                end
            end
        endcase
    end

    assign en_ifid    = reset & en_ifid_c;
    assign en_idex    = reset & en_idex_c;
    assign en_exmem   = reset & en_exmem_c;
    assign en_memwb   = reset & en_memwb_c;
    assign flush_ifid = ~reset | flush_ifid_c;
    assign flush_idex = ~reset | flush_idex_c;

    // Shadow of the ID/EX destination so hazard checks never look at EX data paths.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rd_d    = ex_rd_q;
        ex_load_d  = ex_load_q;
        if (flush_idex) begin
            ex_valid_d = 1'b0;
        end else if (en_idex) begin
            ex_valid_d = id_valid & id_reg_write;
            ex_rd_d    = id_rd;
            ex_load_d  = id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            pend_br_q  <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            ex_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_br_q  <= pend_br_d;
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            ex_load_q  <= ex_load_d;
        end
    end

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (!en_ifid && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; the stall counter checks
// run only when PIPE_HAZARD_STALL_CNT_EN is defined for both files.
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rn;
   logic [4:0] id_rm;
   logic       id_rn_used;
   logic       id_rm_used;
   logic [4:0] id_rd;
   logic       id_reg_write;
   logic       id_mem_read;
   logic       br_taken;
   logic       mem_busy;
   logic       en_ifid;
   logic       en_idex;
   logic       en_exmem;
   logic       en_memwb;
   logic       flush_ifid;
   logic       flush_idex;
`ifdef PIPE_HAZARD_STALL_CNT_EN
   logic [15:0] stall_count;
`endif

   int checks;
   int failures;

   pipe_hazard_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_rn        (id_rn),
      .id_rm        (id_rm),
      .id_rn_used   (id_rn_used),
      .id_rm_used   (id_rm_used),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .br_taken     (br_taken),
      .mem_busy     (mem_busy),
      .en_ifid      (en_ifid),
      .en_idex      (en_idex),
      .en_exmem     (en_exmem),
      .en_memwb     (en_memwb),
      .flush_ifid   (flush_ifid),
`ifdef PIPE_HAZARD_STALL_CNT_EN
      .flush_idex   (flush_idex),
      .stall_count  (stall_count)
`else
      .flush_idex   (flush_idex)
`endif
   );

   // Free-running clock: rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one cycle's ID/EX/MEM inputs just after the falling edge and
   // leaves 1 time unit for the combinational outputs to settle.
   task automatic applyStimulus(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                                input logic rnu, input logic rmu, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic br, input logic busy);
      @(negedge clk);
      id_valid     = v;
      id_rn        = rn;
      id_rm        = rm;
      id_rn_used   = rnu;
      id_rm_used   = rmu;
      id_rd        = rd;
      id_reg_write = rw;
      id_mem_read  = mr;
      br_taken     = br;
      mem_busy     = busy;
      #1;
   endtask

   // Compares {en_ifid,en_idex,en_exmem,en_memwb} and {flush_ifid,flush_idex}.
   task automatic checkOutput(input string tag, input logic [3:0] exp_en, input logic [1:0] exp_fl);
      logic [5:0] obs;
      logic [5:0] exp_v;
      obs   = {en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex};
      exp_v = {exp_en, exp_fl};
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("[TB] FAIL %s observed en/fl=%b expected en/fl=%b", tag, obs, exp_v);
      end
   endtask

`ifdef PIPE_HAZARD_STALL_CNT_EN
   task automatic checkCount(input string tag, input logic [15:0] exp_cnt);
      checks++;
      assert (stall_count === exp_cnt) else begin
         failures++;
         $error("[TB] FAIL %s observed stall_count=%0d expected stall_count=%0d", tag, stall_count, exp_cnt);
      end
   endtask
`endif

   // Directed sequence; each step is one clock cycle with hand-computed outputs.
   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b0;
      id_valid     = 1'b0;
      id_rn        = 5'd0;
      id_rm        = 5'd0;
      id_rn_used   = 1'b0;
      id_rm_used   = 1'b0;
      id_rd        = 5'd0;
      id_reg_write = 1'b0;
      id_mem_read  = 1'b0;
      br_taken     = 1'b0;
      mem_busy     = 1'b0;

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                       5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         checkOutput("reset_hold", 4'b0000, 2'b11);
      end
`ifdef PIPE_HAZARD_STALL_CNT_EN
      checkCount("reset_count", 16'd0);
`endif

      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("reset_release", 4'b1111, 2'b00);

      applyStimulus(1, 0, 0, 0, 0, 5'd3, 1, 1, 0, 0);
      checkOutput("lu_load_in_id", 4'b1111, 2'b00);
      applyStimulus(1, 5'd3, 0, 1, 0, 5'd5, 1, 0, 0, 0);
      checkOutput("lu_rn_stall", 4'b0111, 2'b01);
      applyStimulus(1, 5'd3, 0, 1, 0, 5'd5, 1, 0, 0, 0);
      checkOutput("lu_rn_advance", 4'b1111, 2'b00);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("lu_rn_quiet", 4'b1111, 2'b00);

      applyStimulus(1, 0, 0, 0, 0, 5'd31, 1, 1, 0, 0);
      checkOutput("xzr_load", 4'b1111, 2'b00);
      applyStimulus(1, 5'd31, 5'd31, 1, 1, 5'd2, 0, 0, 0, 0);
      checkOutput("xzr_no_stall", 4'b1111, 2'b00);

      applyStimulus(1, 0, 0, 0, 0, 5'd7, 1, 1, 0, 0);
      checkOutput("lu_rm_load", 4'b1111, 2'b00);
      applyStimulus(1, 5'd1, 5'd7, 0, 1, 5'd8, 0, 0, 0, 0);
      checkOutput("lu_rm_stall", 4'b0111, 2'b01);
      applyStimulus(1, 5'd1, 5'd7, 0, 1, 5'd8, 0, 0, 0, 0);
      checkOutput("lu_rm_advance", 4'b1111, 2'b00);

      applyStimulus(1, 0, 0, 0, 0, 5'd4, 1, 1, 0, 0);
      checkOutput("br_load", 4'b1111, 2'b00);
      applyStimulus(1, 5'd4, 0, 1, 0, 5'd6, 1, 0, 1, 0);
      checkOutput("br_over_lu", 4'b1111, 2'b11);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("br_one_edge", 4'b1111, 2'b00);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
         checkOutput("memw_freeze", 4'b0000, 2'b00);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("memw_resume", 4'b1111, 2'b00);

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("memw_br_rise", 4'b0000, 2'b00);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
         checkOutput("memw_br_wait", 4'b0000, 2'b00);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("memw_br_flush", 4'b1111, 2'b11);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("memw_br_done", 4'b1111, 2'b00);

      applyStimulus(1, 0, 0, 0, 0, 5'd9, 1, 1, 0, 0);
      checkOutput("memw_lu_load", 4'b1111, 2'b00);
      applyStimulus(1, 5'd9, 0, 1, 0, 5'd10, 1, 0, 0, 1);
      checkOutput("memw_lu_wait", 4'b0000, 2'b00);
      applyStimulus(1, 5'd9, 0, 1, 0, 5'd10, 1, 0, 0, 0);
      checkOutput("memw_lu_stall", 4'b0111, 2'b01);
      applyStimulus(1, 5'd9, 0, 1, 0, 5'd10, 1, 0, 0, 0);
      checkOutput("memw_lu_advance", 4'b1111, 2'b00);

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      #1;
      checkOutput("reset_async", 4'b0000, 2'b11);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      checkOutput("reset_release2", 4'b1111, 2'b00);

`ifdef PIPE_HAZARD_STALL_CNT_EN
      checkCount("count_cleared", 16'd0);
      applyStimulus(1, 0, 0, 0, 0, 5'd3, 1, 1, 0, 0);
      applyStimulus(1, 5'd3, 0, 1, 0, 5'd5, 1, 0, 0, 0);
      checkOutput("cnt_lu_stall", 4'b0111, 2'b01);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkCount("count_five", 16'd5);
      for (int i = 0; i < 65539; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkCount("count_saturate", 16'hFFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
